// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM states,
// operation encodings for the sub input, and counter sizing.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Counter must hold indices 0..N-1; at least one bit even when N == 1.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_addsub_digit.sv
// Combinational DIGIT-wide ripple of full-adder stages. Also exposes the
// carry into the top bit of the digit so the caller can form signed overflow.
module addsub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    input  logic             c_in,
    output logic [DIGIT-1:0] s_dig,
    output logic             c_out,
    output logic             c_top
);

    logic carry;

    // Ripple the carry through each bit; c_top keeps the carry entering the last bit.
    always_comb begin
        s_dig = '0;
        carry = c_in;
        c_top = c_in;
        for (int i = 0; i < DIGIT; i++) begin
            s_dig[i] = a_dig[i] ^ b_dig[i] ^ carry;
            c_top    = carry;
            carry    = (a_dig[i] & b_dig[i]) | (carry & (a_dig[i] ^ b_dig[i]));
        end
        c_out = carry;
    end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor. Operands are captured on the accept edge and
// consumed DIGIT bits per clock, LSB first; the result fills sum from the MSB
// end so that after N digits it is correctly aligned.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic               last;
    logic [DIGIT-1:0]   dig_sum;
    logic               dig_cout;
    logic               dig_ctop;
    logic [WIDTH+DIGIT-1:0] sum_wide;

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_dig (a_q[DIGIT-1:0]),
        .b_dig (b_q[DIGIT-1:0]),
        .c_in  (carry_q),
        .s_dig (dig_sum),
        .c_out (dig_cout),
        .c_top (dig_ctop)
    );

    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
    assign last     = (cnt_q == LAST);
    assign sum_wide = {dig_sum, sum_q};

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept from IDLE or DONE, leave RUN after the last digit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: busy while digits are processed, done for the single DONE cycle.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Datapath next values: load on accept, shift one digit per RUN cycle, else hold.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == RUN) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            sum_d   = sum_wide[WIDTH+DIGIT-1:DIGIT];
            carry_d = dig_cout;
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
                cout_d = dig_cout;
                ovf_d  = dig_ctop ^ dig_cout;
            end
        end else if (accept) begin
            a_d     = a;
            b_d     = (sub == OP_SUB) ? ~b : b;
            carry_d = cin ^ sub;
            cnt_d   = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (8/1, 8/4, 16/16), directed
// vectors, expected results queued at issue and checked by per-instance monitors.
module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        start0, cin0, sub0, busy0, done0, cout0, ovf0;
    logic [7:0]  a0, b0, sum0;
    logic        start1, cin1, sub1, busy1, done1, cout1, ovf1;
    logic [7:0]  a1, b1, sum1;
    logic        start2, cin2, sub2, busy2, done2, cout2, ovf2;
    logic [15:0] a2, b2, sum2;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          doneCyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int cyc = 0;
    int nChecks = 0;
    int nFails = 0;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .cin(cin0), .sub(sub0),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_addsub #(.WIDTH(16), .DIGIT(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    // Free-running edge counter used to time done pulses
    always @(posedge clk) cyc <= cyc + 1;

    // Single compare point: counts every comparison and reports mismatches
    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pop the oldest expected result for an instance and compare it with what the DUT shows
    task automatic popCheck(input int sel, input logic [15:0] s, input logic c, input logic o);
        exp_t e;
        int   sz;
        sz = (sel == 0) ? q0.size() : (sel == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL dut%0d_unexpected_done: got done at cycle %0d, expected none", sel, cyc);
        end else begin
            case (sel)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            checkOutput($sformatf("dut%0d_sum", sel), s, e.sum);
            checkOutput($sformatf("dut%0d_cout", sel), 16'(c), 16'(e.cout));
            checkOutput($sformatf("dut%0d_ovf", sel), 16'(o), 16'(e.ovf));
            checkOutput($sformatf("dut%0d_done_cycle", sel), 16'(cyc), 16'(e.doneCyc));
        end
    endtask

    // Monitors sample on the falling edge, away from the active edge
    always @(negedge clk) if (done0 === 1'b1) popCheck(0, {8'h00, sum0}, cout0, ovf0);
    always @(negedge clk) if (done1 === 1'b1) popCheck(1, {8'h00, sum1}, cout1, ovf1);
    always @(negedge clk) if (done2 === 1'b1) popCheck(2, sum2, cout2, ovf2);

    // Issue one operation and queue its hand-computed result and done cycle
    task automatic applyStimulus(input int sel, input bit atOnce,
                                 input logic [15:0] av, input logic [15:0] bv,
                                 input logic cinv, input logic subv,
                                 input logic [15:0] es, input logic ec, input logic eo);
        exp_t e;
        int   n;
        if (!atOnce) @(negedge clk);
        case (sel)
            0: begin a0 = av[7:0]; b0 = bv[7:0]; cin0 = cinv; sub0 = subv; start0 = 1'b1; end
            1: begin a1 = av[7:0]; b1 = bv[7:0]; cin1 = cinv; sub1 = subv; start1 = 1'b1; end
            default: begin a2 = av; b2 = bv; cin2 = cinv; sub2 = subv; start2 = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        n = (sel == 0) ? 8 : (sel == 1) ? 2 : 1;
        e.sum = es;
        e.cout = ec;
        e.ovf = eo;
        e.doneCyc = cyc + n;
        case (sel)
            0: begin
                q0.push_back(e);
                start0 = 1'b0; a0 = ~av[7:0]; b0 = ~bv[7:0]; cin0 = ~cinv; sub0 = ~subv;
                checkOutput("dut0_busy_after_accept", 16'(busy0), 16'd1);
            end
            1: begin
                q1.push_back(e);
                start1 = 1'b0; a1 = ~av[7:0]; b1 = ~bv[7:0]; cin1 = ~cinv; sub1 = ~subv;
                checkOutput("dut1_busy_after_accept", 16'(busy1), 16'd1);
            end
            default: begin
                q2.push_back(e);
                start2 = 1'b0; a2 = ~av; b2 = ~bv; cin2 = ~cinv; sub2 = ~subv;
                checkOutput("dut2_busy_after_accept", 16'(busy2), 16'd1);
            end
        endcase
    endtask

    // Bounded wait for the next done pulse of an instance
    task automatic waitDone(input int sel, output int doneAt);
        bit found;
        logic d;
        found = 1'b0;
        doneAt = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            d = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
            if (d === 1'b1) begin
                found = 1'b1;
                doneAt = cyc;
                break;
            end
        end
        if (!found) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL dut%0d_done_timeout: got no done in 40 cycles, expected one", sel);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busyCnt;
        int doneAt;
        int firstDone;
        bit sawDone;

        rst_n = 1'b0;
        start0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 16'(busy0), 16'd0);
        checkOutput("reset_done", 16'(done0), 16'd0);
        checkOutput("reset_sum",  16'(sum0),  16'd0);
        checkOutput("reset_cout", 16'(cout0), 16'd0);
        checkOutput("reset_ovf",  16'(ovf0),  16'd0);
        rst_n = 1'b1;

        // Basic add with busy window and hold-after-done checks
        applyStimulus(0, 1'b0, 16'h5A, 16'h3C, 1'b0, 1'b0, 16'h96, 1'b0, 1'b1);
        busyCnt = 0;
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                sawDone = 1'b1;
                break;
            end
            if (busy0 === 1'b1) busyCnt++;
        end
        checkOutput("first_done_seen", 16'(sawDone), 16'd1);
        checkOutput("busy_cycles", 16'(busyCnt), 16'd8);
        checkOutput("busy_in_done", 16'(busy0), 16'd0);
        @(negedge clk);
        checkOutput("done_one_cycle", 16'(done0), 16'd0);
        checkOutput("sum_hold_idle", 16'(sum0), 16'h96);

        applyStimulus(0, 1'b0, 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0);
        waitDone(0, doneAt);
        applyStimulus(0, 1'b0, 16'h7F, 16'h00, 1'b1, 1'b0, 16'h80, 1'b0, 1'b1);
        waitDone(0, doneAt);
        applyStimulus(0, 1'b0, 16'h10, 16'h20, 1'b0, 1'b1, 16'hF0, 1'b0, 1'b0);
        waitDone(0, doneAt);
        applyStimulus(0, 1'b0, 16'h80, 16'h01, 1'b0, 1'b1, 16'h7F, 1'b1, 1'b1);
        waitDone(0, doneAt);
        applyStimulus(0, 1'b0, 16'h05, 16'h05, 1'b1, 1'b1, 16'hFF, 1'b0, 1'b0);
        waitDone(0, doneAt);

        // Start while busy is ignored; start during done is accepted back-to-back
        applyStimulus(0, 1'b0, 16'h33, 16'h44, 1'b0, 1'b0, 16'h77, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        start0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF; sub0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        waitDone(0, firstDone);
        applyStimulus(0, 1'b1, 16'h01, 16'h02, 1'b0, 1'b1, 16'hFF, 1'b0, 1'b0);
        waitDone(0, doneAt);
        checkOutput("b2b_done_gap", 16'(doneAt - firstDone), 16'd9);

        // Asynchronous reset mid-operation
        applyStimulus(0, 1'b0, 16'h12, 16'h34, 1'b0, 1'b0, 16'h46, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 16'(busy0), 16'd0);
        checkOutput("midrst_done", 16'(done0), 16'd0);
        checkOutput("midrst_sum",  16'(sum0),  16'd0);
        checkOutput("midrst_cout", 16'(cout0), 16'd0);
        checkOutput("midrst_ovf",  16'(ovf0),  16'd0);
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) sawDone = 1'b1;
        end
        checkOutput("no_done_after_reset", 16'(sawDone), 16'd0);
        applyStimulus(0, 1'b0, 16'h22, 16'h11, 1'b0, 1'b0, 16'h33, 1'b0, 1'b0);
        waitDone(0, doneAt);

        // Wider digits
        applyStimulus(1, 1'b0, 16'h5A, 16'h3C, 1'b0, 1'b0, 16'h96, 1'b0, 1'b1);
        waitDone(1, doneAt);
        applyStimulus(1, 1'b0, 16'h80, 16'h01, 1'b0, 1'b1, 16'h7F, 1'b1, 1'b1);
        waitDone(1, doneAt);
        applyStimulus(2, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        waitDone(2, doneAt);

        repeat (3) @(negedge clk);
        checkOutput("dut0_queue_empty", 16'(q0.size()), 16'd0);
        checkOutput("dut1_queue_empty", 16'(q1.size()), 16'd0);
        checkOutput("dut2_queue_empty", 16'(q2.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised digit-serial adder/subtractor, successor to the combinational single-bit full-adder cell.
- Processes WIDTH-bit operands DIGIT bits per clock through one DIGIT-wide ripple cell plus a registered carry.
- Trades latency for area. Provides a start/busy/done handshake and signed-overflow detection.
- Used wherever wide add/sub is infrequent and area matters.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT, and WIDTH >= 2.
- DIGIT, 1, bits processed per cycle; N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only when not busy.
- a  input  WIDTH  operand A; captured on the accept edge.
- b  input  WIDTH  operand B; captured on the accept edge.
- cin  input  1  carry-in (add) or borrow-in (sub); captured on the accept edge.
- sub  input  1  0: a+b+cin; 1: a-b-cin; captured on the accept edge.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse; results valid from this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  raw carry out of the MSB; in sub mode, borrow = ~cout.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; shift registers, carry and counter cleared. Reset mid-operation aborts the operation with no partial result, and no done is issued.
- States: IDLE, RUN, DONE.
- Accept edge E0: start=1 while in IDLE or DONE.
  - Load A and B shift registers; B is loaded inverted when sub=1.
  - Carry register loads cin ^ sub, so subtraction computes a + ~b + ~cin = a - b - cin.
  - Counter = 0; go to RUN; busy=1 from E0.
- RUN, edges E1..EN: each edge adds the low DIGIT bits of A and B plus the carry register.
  - Shift the DIGIT sum bits into sum from the MSB end; shift A and B right by DIGIT.
  - Update the carry register; increment the counter.
  - On the edge processing the last digit (counter = N-1):
    - Latch cout = carry out of bit WIDTH-1.
    - Latch ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1; the carry into the MSB is taken inside the DIGIT cell.
    - Go to DONE.
- DONE: busy=0, done=1 for exactly one cycle. done becomes visible N cycles after E0.
  - start=1 in DONE is accepted (back-to-back throughput of one operation per N+1 cycles).
  - Otherwise go to IDLE.
- start while busy is ignored. It is not queued, and the operation in progress is undisturbed.
- sum, cout and ovf change only during RUN and hold their values in IDLE/DONE until the next accept. During RUN, sum is a partial value and is not valid.
- Input operands may change freely after E0.
- Counter width = max(1, clog2(N)). With N=1 (DIGIT=WIDTH), RUN lasts one cycle.
- Arithmetic is unsigned modulo 2^WIDTH; ovf is meaningful only for signed interpretation.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/RUN/DONE);
  - a function computing counter width from WIDTH/DIGIT;
  - the OP_ADD/OP_SUB constants for the sub input.
- One sub-module is natural: addsub_digit. It is a combinational DIGIT-wide ripple of full-adder stages.
  - Outputs: DIGIT sum bits, carry out, and carry into the top bit (needed for ovf).
  - The top level holds only the FSM, counter, shift registers and carry flop.

Test Plan:
- WIDTH=8, DIGIT=1; start with a=0x5A, b=0x3C, cin=0, sub=0 -> done pulses 8 cycles after the accept edge; sum=0x96, cout=0, ovf=1; busy high for cycles 1..8.
- a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- sub=1: a=0x10, b=0x20, cin=0 -> sum=0xF0, cout=0 (borrow), ovf=0. a=0x80, b=0x01, cin=0 -> sum=0x7F, cout=1, ovf=1. a=0x05, b=0x05, cin=1 -> sum=0xFF, cout=0.
- Pulse start again at cycle 3 of an operation with different operands -> ignored; first result unchanged. Start held high in the done cycle -> second operation accepted; its done arrives 9 cycles after the first done.
- Assert rst_n low at cycle 4 of RUN -> busy, done, sum, cout, ovf all 0 immediately (asynchronous); no done follows. A new start after release gives a correct result.
- WIDTH=8, DIGIT=4: a=0x5A, b=0x3C -> done 2 cycles after accept, sum=0x96, ovf=1. WIDTH=16, DIGIT=16: a=0xFFFF, b=0x0001 -> done 1 cycle after accept, sum=0x0000, cout=1.
